// File: rtl/sg_pkg.sv
// Shared encodings for the multi-voice signal generator: waveform and register
// codes, CTRL bit positions and the noise LFSR definition.
package sg_pkg;

  typedef enum logic [1:0] {
    WAVE_SQ    = 2'b00,
    WAVE_PULSE = 2'b01,
    WAVE_SAW   = 2'b10,
    WAVE_NOISE = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    REG_FREQ_LO = 2'd0,
    REG_FREQ_HI = 2'd1,
    REG_CTRL    = 2'd2,
    REG_SHAPE   = 2'd3
  } reg_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_WAVE_LSB = 1;
  localparam int CTRL_CLR_BIT  = 3;
  localparam int SHAPE_DUTY_LSB = 4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One Galois shift: output bit 0 feeds back through the tap mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sg_voice.sv
// One generator voice: its register bank, phase accumulator, noise LFSR and the
// waveform-to-amplitude mapping.
module sg_voice
  import sg_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int DATA_W  = 8,
  parameter int AMP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [1:0]        wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  output logic [AMP_W-1:0]  amplitude
);

  localparam int MSB = PHASE_W - 1;

  logic [PHASE_W-1:0] freq;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_sum;
  logic [15:0]        lfsr;
  logic               enable;
  wave_e              wave;
  logic [3:0]         duty;
  logic [AMP_W-1:0]   level;

  logic wr_ctrl;
  logic run;
  logic phase_clr;
  logic wrap;
  logic wave_bit;

  assign wr_ctrl   = wr_en && (wr_reg == REG_CTRL);
  // A CTRL write landing on a tick already governs that tick.
  assign run       = tick && (wr_ctrl ? wr_data[CTRL_EN_BIT] : enable);
  assign phase_clr = wr_ctrl && wr_data[CTRL_CLR_BIT];
  assign acc_sum   = acc + freq;
  assign wrap      = run && !phase_clr && acc[MSB] && !acc_sum[MSB];

  // NOTE: every register here uses non-blocking assignment so all reads in this
  // block see pre-edge values, which is what makes old-freq-on-collision hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq   <= '0;
      acc    <= '0;
      lfsr   <= LFSR_SEED;
      enable <= 1'b0;
      wave   <= WAVE_SQ;
      duty   <= '0;
      level  <= '0;
    end else begin
      if (phase_clr)  acc <= '0;
      else if (run)   acc <= acc_sum;
      if (wrap)       lfsr <= lfsr_next(lfsr);
      if (wr_en) begin
        unique case (wr_reg)
          REG_FREQ_LO: freq[DATA_W-1:0]       <= wr_data;
          REG_FREQ_HI: freq[PHASE_W-1:DATA_W] <= wr_data[PHASE_W-DATA_W-1:0];
          REG_CTRL: begin
            enable <= wr_data[CTRL_EN_BIT];
            wave   <= wave_e'(wr_data[CTRL_WAVE_LSB +: 2]);
          end
          default: begin
            duty  <= wr_data[SHAPE_DUTY_LSB +: 4];
            level <= wr_data[AMP_W-1:0];
          end
        endcase
      end
    end
  end

  // NOTE: defaults first so no path through this block leaves an output
  // unassigned and infers a latch.
  always_comb begin
    wave_bit  = 1'b0;
    amplitude = '0;
    unique case (wave)
      WAVE_SQ:    wave_bit = acc[MSB];
      WAVE_PULSE: wave_bit = acc[MSB-:4] < duty;
      WAVE_NOISE: wave_bit = lfsr[0];
      default:    wave_bit = |acc[MSB-:AMP_W];
    endcase
    if (enable) begin
      if (wave == WAVE_SAW) amplitude = acc[MSB-:AMP_W];
      else                  amplitude = wave_bit ? level : '0;
    end
  end

endmodule

// File: rtl/multi_voice_signal_gen.sv
// Multi-voice phase-accumulator generator: pin-strobed register writes, a tick
// prescaler, NUM_VOICES voices and a first-order sigma-delta mixer.
module multi_voice_signal_gen
  import sg_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int DATA_W     = 8,
  parameter int AMP_W      = 4,
  parameter int PRESCALE   = 50,
  localparam int ADDR_W    = $clog2(NUM_VOICES) + 2,
  localparam int SUM_W     = AMP_W + $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_strobe,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  audio_out,
  output logic [NUM_VOICES-1:0] voice_out,
  output logic                  tick_out
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int CNT_W   = $clog2(PRESCALE);

  logic [1:0]         strobe_sync;
  logic               strobe_prev;
  logic               commit;
  logic [VOICE_W-1:0] voice_sel;
  logic [1:0]         reg_sel;
  logic [CNT_W-1:0]   count;
  logic               tick;
  logic [AMP_W-1:0]   amp [NUM_VOICES];
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   err;
  logic [SUM_W:0]     mix;

  // The strobe is asynchronous to clk; address/data are quasi-static and are
  // only sampled on the commit cycle, after the strobe has been synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      strobe_prev <= 1'b0;
    end else begin
      strobe_sync <= {strobe_sync[0], wr_strobe};
      strobe_prev <= strobe_sync[1];
    end
  end

  assign commit    = strobe_sync[1] && !strobe_prev;
  assign voice_sel = wr_addr[ADDR_W-1:2];
  assign reg_sel   = wr_addr[1:0];

  assign tick = ena && (count == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= tick;
      if (ena) count <= tick ? '0 : count + 1'b1;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    sg_voice #(
      .PHASE_W (PHASE_W),
      .DATA_W  (DATA_W),
      .AMP_W   (AMP_W)
    ) u_voice (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr_en     (commit && (voice_sel == VOICE_W'(v))),
      .wr_reg    (reg_sel),
      .wr_data   (wr_data),
      .amplitude (amp[v])
    );
    assign voice_out[v] = |amp[v];
  end

  // SUM_W leaves exactly enough headroom for every voice at full scale.
  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) sum = sum + SUM_W'(amp[v]);
  end

  assign mix = {1'b0, err} + {1'b0, sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= '0;
      audio_out <= 1'b0;
    end else begin
      err       <= mix[SUM_W-1:0];
      audio_out <= mix[SUM_W];
    end
  end

endmodule

// File: tb/tb_multi_voice_signal_gen.sv
// Self-checking bench: directed scenarios plus random register traffic, all
// compared every cycle against a behavioural model of the generator.
module tb_multi_voice_signal_gen;

  localparam int NV     = 4;
  localparam int PS     = 4;
  localparam int ADDR_W = 4;
  localparam int SUM_M  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       audio_out;
  logic [3:0] voice_out;
  logic       tick_out;

  int n_cmp = 0;
  int n_bad = 0;

  multi_voice_signal_gen #(
    .NUM_VOICES (NV),
    .PHASE_W    (16),
    .DATA_W     (8),
    .AMP_W      (4),
    .PRESCALE   (PS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .audio_out (audio_out),
    .voice_out (voice_out),
    .tick_out  (tick_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_freq[NV], m_acc[NV], m_lfsr[NV], m_wave[NV], m_duty[NV], m_level[NV];
  bit          m_en[NV];
  int          m_cnt, m_err;
  bit          m_audio, m_tick_out;
  bit          h[3];  // strobe level seen at the previous three clock edges

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_freq[v] = 0; m_acc[v] = 0; m_lfsr[v] = 16'hACE1;
      m_wave[v] = 0; m_duty[v] = 0; m_level[v] = 0; m_en[v] = 0;
    end
    m_cnt = 0; m_err = 0; m_audio = 0; m_tick_out = 0;
    h[0] = 0; h[1] = 0; h[2] = 0;
  endtask

  function automatic int unsigned amp(int v);
    bit w;
    if (!m_en[v]) return 0;
    case (m_wave[v])
      0: w = (m_acc[v] >> 15) != 0;
      1: w = ((m_acc[v] >> 12) & 15) < m_duty[v];
      2: return (m_acc[v] >> 12) & 15;
      default: w = (m_lfsr[v] & 1) != 0;
    endcase
    return w ? m_level[v] : 0;
  endfunction

  function automatic logic [3:0] exp_voice();
    logic [3:0] r;
    for (int v = 0; v < NV; v++) r[v] = amp(v) != 0;
    return r;
  endfunction

  task automatic model_step();
    bit tick, commit, hit, en_eff, clr;
    int sum, s, r;
    int unsigned a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick   = ena && (m_cnt == PS - 1);
    commit = h[1] && !h[2];
    sum = 0;
    for (int v = 0; v < NV; v++) sum += amp(v);
    s = m_err + sum;
    m_audio    = s >= SUM_M;
    m_err      = s % SUM_M;
    m_tick_out = tick;
    for (int v = 0; v < NV; v++) begin
      hit    = commit && (int'(wr_addr) >> 2) == v;
      r      = int'(wr_addr) & 3;
      en_eff = m_en[v];
      clr    = 0;
      if (hit && r == 2) begin
        en_eff = wr_data[0];
        clr    = wr_data[3];
      end
      if (clr) m_acc[v] = 0;
      else if (tick && en_eff) begin
        a = (m_acc[v] + m_freq[v]) % 65536;
        if (m_acc[v] >= 32768 && a < 32768)
          m_lfsr[v] = (m_lfsr[v] >> 1) ^ (((m_lfsr[v] & 1) != 0) ? 32'hB400 : 32'h0);
        m_acc[v] = a;
      end
      if (hit) begin
        case (r)
          0: m_freq[v] = (m_freq[v] & 32'hFF00) | int'(wr_data);
          1: m_freq[v] = (m_freq[v] & 32'h00FF) | (int'(wr_data) << 8);
          2: begin m_en[v] = wr_data[0]; m_wave[v] = int'(wr_data[2:1]); end
          default: begin m_duty[v] = int'(wr_data[7:4]); m_level[v] = int'(wr_data[3:0]); end
        endcase
      end
    end
    h[2] = h[1]; h[1] = h[0]; h[0] = wr_strobe;
    if (ena) m_cnt = (m_cnt + 1) % PS;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    check("audio", 32'(audio_out), 32'(m_audio));
    check("voice", 32'(voice_out), 32'(exp_voice()));
    check("tick",  32'(tick_out),  32'(m_tick_out));
  endtask

  task automatic wr(input int addr, input int data);
    wr_addr   = 4'(addr);
    wr_data   = 8'(data);
    wr_strobe = 1'b1;
    repeat (4) cyc();
    wr_strobe = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_audio", 32'(audio_out), 0);
    check("rst_async_voice", 32'(voice_out), 0);
    check("rst_async_tick",  32'(tick_out),  0);
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic count_voice(input int v, input int ncyc, output int ones);
    ones = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      ones += int'(voice_out[v]);
    end
  endtask

  int cnt, n;

  initial begin
    rst_n = 1'b0; ena = 1'b0; wr_strobe = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #1;
    cyc();
    cyc();
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (8) cyc();
    check("idle_voice", 32'(voice_out), 0);
    check("idle_audio", 32'(audio_out), 0);

    // Prescaler: one tick per PS clocks, frozen while ena is low.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cyc(); cnt += int'(tick_out); end
    check("tick_per_16", cnt, 4);
    ena = 1'b0;
    cyc();
    cnt = 0;
    for (int i = 0; i < 9; i++) begin cyc(); cnt += int'(tick_out); end
    check("tick_held", cnt, 0);
    ena = 1'b1;
    repeat (12) cyc();

    // Square on voice 0: period 4 ticks, 50 percent.
    wr(1, 8'h40); wr(0, 8'h00); wr(3, 8'h0F); wr(2, 8'h01);
    count_voice(0, 64, cnt);
    check("square_high_of_64", cnt, 32);

    // Reset while the tone is running, then pulse with duty 4.
    do_reset();
    repeat (6) cyc();
    check("post_reset_voice", 32'(voice_out), 0);
    wr(1, 8'h10); wr(0, 8'h00); wr(3, 8'h4F); wr(2, 8'h03);
    count_voice(0, 64, cnt);
    check("pulse_high_of_64", cnt, 16);

    // Mixer: voice 0 frozen high at level 15.
    do_reset();
    ena = 1'b0;
    wr(1, 8'h80); wr(3, 8'h0F); wr(2, 8'h01);
    ena = 1'b1;
    n = 0;
    while (voice_out[0] !== 1'b1 && n < 20) begin cyc(); n++; end
    ena = 1'b0;
    check("hold_reached", 32'(voice_out[0]), 1);
    wr(1, 8'h00);
    ena = 1'b1;
    repeat (8) cyc();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin cyc(); cnt += int'(audio_out); end
    check("audio_ones_of_64", cnt, 15);

    // Commit lands on the third edge; a held strobe never writes again.
    wr_addr = 4'd3; wr_data = 8'h00; wr_strobe = 1'b1;
    cyc(); check("commit_edge1", 32'(voice_out[0]), 1);
    cyc(); check("commit_edge2", 32'(voice_out[0]), 1);
    cyc(); check("commit_edge3", 32'(voice_out[0]), 0);
    cyc();
    wr_data = 8'h0F;
    repeat (4) cyc();
    check("strobe_held_no_rewrite", 32'(voice_out[0]), 0);
    wr_strobe = 1'b0;
    repeat (3) cyc();

    // Noise on voice 1 over more than 100 accumulator wraps.
    do_reset();
    wr(5, 8'h80); wr(7, 8'h0F); wr(6, 8'h07);
    repeat (820) cyc();

    // Saw on voice 2, then phase_clr arriving on a tick cycle.
    wr(9, 8'h10); wr(10, 8'h05);
    repeat (20) cyc();
    n = 0;
    while (m_cnt != 1 && n < 10) begin cyc(); n++; end
    wr_addr = 4'd10; wr_data = 8'h0D; wr_strobe = 1'b1;
    repeat (3) cyc();
    check("clr_on_tick_tick", 32'(tick_out), 1);
    check("clr_on_tick_acc0", 32'(voice_out[2]), 0);
    cyc();
    wr_strobe = 1'b0;
    repeat (3) cyc();

    // Random register traffic, ena toggling and occasional resets.
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 99));
      if (n < 70)      wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      else if (n < 88) begin ena = 1'($urandom_range(0, 1)); repeat (3) cyc(); end
      else if (n < 97) repeat (int'($urandom_range(1, 12))) cyc();
      else             do_reset();
    end
    ena = 1'b1;
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
